// File: rtl/gc_conf_pkg.sv
// Shared definitions for the Global Controller configuration sequencer.
package gc_conf_pkg;

  // Target select codes on the shared conf bus
  localparam logic [2:0] SEL_IDLE   = 3'b000;
  localparam logic [2:0] SEL_STRIDE = 3'b011;

  // Error codes reported on err_code while error=1
  localparam logic [1:0] ERR_BAD_COUNT     = 2'b00;
  localparam logic [1:0] ERR_ALREADY_ACKED = 2'b01;
  localparam logic [1:0] ERR_EARLY_ACK     = 2'b10;
  localparam logic [1:0] ERR_ACK_TIMEOUT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_SEL,
    ST_HDR_CNT,
    ST_SEND,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERR
  } conf_state_e;

endpackage

// File: rtl/gc_conf_ack_timer.sv
// Saturating WAIT_ACK cycle timer. expired_o is registered one cycle early so it
// is high in the cycle whose closing edge takes the count to ACK_TIMEOUT.
module gc_conf_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic conf_clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] count_q, count_d;
  logic          expired_q, expired_d;

  // Next count: clear wins, otherwise count up to ACK_TIMEOUT and hold
  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    if (clear_i) begin
      count_d   = '0;
      expired_d = 1'b0;
    end else if (enable_i) begin
      if (count_q != TW'(ACK_TIMEOUT)) count_d = count_q + TW'(1);
      if (count_q == TW'(ACK_TIMEOUT - 2)) expired_d = 1'b1;
    end
  end

  // Timer registers
  always_ff @(posedge conf_clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/gc_conf_sequencer.sv
// Configuration master: parses a header-framed word stream and issues each
// target's payload on conf_bus/sel, one word per cycle, then waits for its ack.
module gc_conf_sequencer
  import gc_conf_pkg::*;
#(
  parameter int unsigned CONF_WIDTH   = 8,
  parameter int unsigned SELECT_WIDTH = 3,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic                         conf_clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CONF_WIDTH-1:0]        src_data,
  input  logic                         src_valid,
  output logic                         src_ready,
  output logic [CONF_WIDTH-1:0]        conf_bus,
  output logic [SELECT_WIDTH-1:0]      sel,
  input  logic [(2**SELECT_WIDTH)-1:0] conf_ack_bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code
);

  conf_state_e             state_q, state_d;
  logic [SELECT_WIDTH-1:0] target_q, target_d;
  logic [CONF_WIDTH-1:0]   remaining_q, remaining_d;
  logic [CONF_WIDTH-1:0]   conf_bus_q, conf_bus_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [1:0]              err_code_q, err_code_d;

  logic [SELECT_WIDTH-1:0] hdr_code_c;
  logic                    tgt_ack_c;
  logic                    accept_c;
  logic                    timer_clr_c;
  logic                    timer_en_c;
  logic                    timer_expired;

  assign hdr_code_c = src_data[SELECT_WIDTH-1:0];
  assign tgt_ack_c  = conf_ack_bus[target_q];

  // Ready is decoded straight from the state so a late ack blocks the word it collides with
  assign src_ready = (state_q == ST_HDR_SEL) || (state_q == ST_HDR_CNT) ||
                     ((state_q == ST_SEND) && !tgt_ack_c);
  assign accept_c  = src_valid && src_ready;

  assign timer_en_c  = (state_q == ST_WAIT_ACK);
  assign timer_clr_c = !timer_en_c;

  gc_conf_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .conf_clk  (conf_clk),
    .reset     (reset),
    .clear_i   (timer_clr_c),
    .enable_i  (timer_en_c),
    .expired_o (timer_expired)
  );

  // Next-state and registered-output decode; sel drops to idle unless a word is issued
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    conf_bus_d  = conf_bus_q;
    sel_d       = SELECT_WIDTH'(SEL_IDLE);
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR_SEL;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = 2'b00;
        end
      end
      ST_HDR_SEL: begin
        if (accept_c) begin
          if (hdr_code_c == SELECT_WIDTH'(SEL_IDLE)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            target_d = hdr_code_c;
            if (conf_ack_bus[hdr_code_c]) begin
              state_d    = ST_ERR;
              busy_d     = 1'b0;
              error_d    = 1'b1;
              err_code_d = ERR_ALREADY_ACKED;
            end else begin
              state_d = ST_HDR_CNT;
            end
          end
        end
      end
      ST_HDR_CNT: begin
        if (accept_c) begin
          if (src_data == '0) begin
            state_d    = ST_ERR;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_BAD_COUNT;
          end else begin
            remaining_d = src_data;
            state_d     = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (tgt_ack_c) begin
          state_d    = ST_ERR;
          busy_d     = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_EARLY_ACK;
        end else if (accept_c) begin
          conf_bus_d  = src_data;
          sel_d       = target_q;
          remaining_d = remaining_q - CONF_WIDTH'(1);
          if (remaining_q == CONF_WIDTH'(1)) state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (tgt_ack_c) begin
          state_d = ST_HDR_SEL;
        end else if (timer_expired) begin
          state_d    = ST_ERR;
          busy_d     = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_ACK_TIMEOUT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus word immediately
  always_ff @(posedge conf_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      remaining_q <= '0;
      conf_bus_q  <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      conf_bus_q  <= conf_bus_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign conf_bus = conf_bus_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_gc_conf_sequencer.sv
// Scoreboard bench for gc_conf_sequencer with a stride-selector receiver model.
module tb_gc_conf_sequencer;
  import gc_conf_pkg::*;

  localparam int unsigned CW = 8;
  localparam int unsigned SW = 3;

  typedef logic [7:0] word_t;
  typedef struct packed {
    logic [2:0] sel_f;
    logic [7:0] data_f;
  } exp_t;

  logic          conf_clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] src_data = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [CW-1:0] conf_bus;
  logic [SW-1:0] sel;
  logic [7:0]    conf_ack_bus;
  logic          busy, done, error;
  logic [1:0]    err_code;

  always #5 conf_clk = ~conf_clk;

  gc_conf_sequencer #(
    .CONF_WIDTH   (CW),
    .SELECT_WIDTH (SW),
    .ACK_TIMEOUT  (15)
  ) dut (
    .conf_clk     (conf_clk),
    .reset        (reset),
    .start        (start),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .conf_bus     (conf_bus),
    .sel          (sel),
    .conf_ack_bus (conf_ack_bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Receivers: capture while selected and not yet acked; ack once full
  int    cap [8] = '{0, 3, 5, 9, 1, 2, 4, 6};
  int    rx_cnt [8];
  word_t mat [9];
  bit    tie3 = 1'b0;

  always @(posedge conf_clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 8; c++) rx_cnt[c] <= 0;
    end else begin
      for (int c = 1; c < 8; c++) begin
        if (int'(sel) == c && !conf_ack_bus[c]) begin
          if (c == int'(SEL_STRIDE) && rx_cnt[c] < 9) mat[rx_cnt[c]] <= conf_bus;
          rx_cnt[c] <= rx_cnt[c] + 1;
        end
      end
    end
  end

  always_comb begin
    conf_ack_bus = '0;
    for (int c = 1; c < 8; c++)
      conf_ack_bus[c] = (rx_cnt[c] == cap[c]) && !(c == 3 && tie3);
  end

  // Reference model state
  exp_t  exp_q [$];
  int    m_cnt [8];
  bit    m_ack [8];
  word_t m_mat [9];

  // Predict bus words and outcome (-1 done, else err code) from the stream rules.
  // A word offered in the cycle right after the filling word still gets through,
  // because the receiver's ack only becomes visible one cycle after its capture.
  function automatic int predict(input word_t s[$], input int g[$]);
    int i = 0;
    int code, n;
    bit fresh;
    exp_t e;
    while (i < s.size()) begin
      code = int'(s[i] & 8'h07);
      if (code == 0) return -1;
      if (m_ack[code]) return int'(ERR_ALREADY_ACKED);
      n = int'(s[i+1]);
      if (n == 0) return int'(ERR_BAD_COUNT);
      fresh = 1'b0;
      for (int j = 0; j < n; j++) begin
        e.sel_f  = 3'(code);
        e.data_f = s[i+2+j];
        if (m_ack[code]) begin
          if (!(fresh && g[i+2+j] == 0)) return int'(ERR_EARLY_ACK);
          fresh = 1'b0;
          exp_q.push_back(e);
        end else begin
          exp_q.push_back(e);
          if (code == 3 && m_cnt[3] < 9) m_mat[m_cnt[3]] = s[i+2+j];
          m_cnt[code]++;
          if (m_cnt[code] == cap[code] && !(code == 3 && tie3)) begin
            m_ack[code] = 1'b1;
            fresh = 1'b1;
          end
        end
      end
      if (!m_ack[code]) return int'(ERR_ACK_TIMEOUT);
      i += 2 + n;
    end
    return -2;
  endfunction

  // Monitor: pop the scoreboard whenever a word is on the bus
  int   cyc = 0, nwords = 0, first_cyc = 0, last_cyc = 0, err_rise = 0;
  logic err_prev = 1'b0;
  exp_t mon_e;

  always @(negedge conf_clk) begin
    cyc++;
    if (reset) begin
      err_prev = 1'b0;
    end else begin
      if (sel != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word_sel", int'(sel), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_sel", int'(sel), int'(mon_e.sel_f));
          chk("word_data", int'(conf_bus), int'(mon_e.data_f));
        end
        if (nwords == 0) first_cyc = cyc;
        last_cyc = cyc;
        nwords++;
      end
      if (error && !err_prev) err_rise = cyc;
      err_prev = error;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    src_valid = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      m_cnt[c] = 0;
      m_ack[c] = 1'b0;
    end
    repeat (2) @(negedge conf_clk);
    reset = 1'b0;
    @(negedge conf_clk);
  endtask

  task automatic drive(input word_t s[$], input int g[$], input int abort_after, output bit aborted);
    int i = 0, gl, npay = 0, budget = 0;
    bit acc;
    aborted = 1'b0;
    @(negedge conf_clk);
    start = 1'b1;
    @(negedge conf_clk);
    start = 1'b0;
    gl = g[0];
    while (i < s.size() && busy && budget < 3000) begin
      budget++;
      if (gl > 0) begin
        src_valid = 1'b0;
        src_data = CW'($urandom);
        gl--;
        @(negedge conf_clk);
      end else begin
        src_valid = 1'b1;
        src_data = s[i];
        #1;
        acc = src_ready;
        @(negedge conf_clk);
        if (acc) begin
          if (i >= 2) npay++;
          i++;
          if (i < s.size()) gl = g[i];
          if (abort_after > 0 && npay == abort_after) begin
            aborted = 1'b1;
            break;
          end
        end
      end
    end
    src_valid = 1'b0;
    chk("drive_budget_expired", int'(budget >= 3000), 0);
  endtask

  task automatic finish_run(input int outcome, input string tag);
    int w = 0;
    while (busy && w < 100) begin
      @(negedge conf_clk);
      w++;
    end
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), int'(outcome == -1));
    chk({tag, "_error"}, int'(error), int'(outcome >= 0));
    if (outcome >= 0) chk({tag, "_err_code"}, int'(err_code), outcome);
    chk({tag, "_src_ready"}, int'(src_ready), 0);
    chk({tag, "_sb_drain"}, exp_q.size(), 0);
    @(negedge conf_clk);
  endtask

  task automatic run(input word_t s[$], input int g[$], input string tag);
    bit ab;
    int outcome;
    nwords = 0;
    outcome = predict(s, g);
    drive(s, g, 0, ab);
    finish_run(outcome, tag);
  endtask

  task automatic chk_matrix(input string tag);
    for (int k = 0; k < 9; k++) chk({tag, "_matrix"}, int'(mat[k]), int'(m_mat[k]));
  endtask

  function automatic void load_stream(output word_t s[$], input word_t base, input int n);
    s.delete();
    s.push_back(word_t'(SEL_STRIDE));
    s.push_back(word_t'(n));
    for (int k = 0; k < n; k++) s.push_back(base + word_t'(k));
    s.push_back(8'h00);
  endfunction

  function automatic void zero_gaps(output int g[$], input int n, input int val);
    g.delete();
    for (int k = 0; k < n; k++) g.push_back(val);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    word_t s[$];
    int    g[$];
    bit    ab;
    int    outcome, nt, code, n, pick;

    // Reset values
    repeat (2) @(negedge conf_clk);
    chk("rst_conf_bus", int'(conf_bus), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_src_ready", int'(src_ready), 0);
    do_reset();

    // 1: back-to-back load of the stride selector
    load_stream(s, 8'h01, 9);
    zero_gaps(g, s.size(), 0);
    run(s, g, "t1");
    chk("t1_nwords", nwords, 9);
    chk("t1_consecutive", last_cyc - first_cyc, 8);
    chk_matrix("t1");

    // 2: src_valid low every other cycle
    do_reset();
    load_stream(s, 8'h11, 9);
    zero_gaps(g, s.size(), 1);
    run(s, g, "t2");
    chk("t2_nwords", nwords, 9);
    chk_matrix("t2");

    // 3: ten words to a nine-word receiver
    do_reset();
    load_stream(s, 8'h21, 10);
    zero_gaps(g, s.size(), 0);
    g[11] = 1;
    run(s, g, "t3");
    chk("t3_nwords", nwords, 9);

    // 4: receiver never acks
    tie3 = 1'b1;
    do_reset();
    load_stream(s, 8'h55, 1);
    zero_gaps(g, s.size(), 0);
    run(s, g, "t4");
    chk("t4_timeout_cycles", err_rise - last_cyc, 15);
    tie3 = 1'b0;

    // 5: bad count, recovery by start, then reload without reset
    do_reset();
    s = '{8'h03, 8'h00};
    zero_gaps(g, s.size(), 0);
    run(s, g, "t5a");
    load_stream(s, 8'h31, 9);
    zero_gaps(g, s.size(), 0);
    run(s, g, "t5b");
    chk_matrix("t5b");
    load_stream(s, 8'hAA, 1);
    zero_gaps(g, s.size(), 0);
    run(s, g, "t5c");

    // 6: reset after the 4th payload word, then a clean reload
    do_reset();
    load_stream(s, 8'h41, 9);
    zero_gaps(g, s.size(), 0);
    nwords = 0;
    outcome = predict(s, g);
    drive(s, g, 4, ab);
    chk("t6_aborted", int'(ab), 1);
    chk("t6_outcome_done", outcome, -1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_sel", int'(sel), 0);
    chk("t6_rst_conf_bus", int'(conf_bus), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_src_ready", int'(src_ready), 0);
    do_reset();
    load_stream(s, 8'h61, 9);
    zero_gaps(g, s.size(), 0);
    run(s, g, "t6");
    chk_matrix("t6");

    // Randomized multi-target streams
    for (int it = 0; it < 24; it++) begin
      do_reset();
      s.delete();
      g.delete();
      nt = $urandom_range(1, 3);
      for (int t = 0; t < nt; t++) begin
        code = $urandom_range(1, 7);
        pick = $urandom_range(0, 6);
        case (pick)
          0, 1, 2: n = cap[code];
          3:       n = cap[code] - 1;
          4:       n = cap[code] + 1;
          5:       n = cap[code] + 2;
          default: n = 0;
        endcase
        s.push_back(word_t'((($urandom_range(0, 31)) << 3) | code));
        s.push_back(word_t'(n));
        for (int k = 0; k < n; k++) s.push_back(word_t'($urandom));
      end
      s.push_back(word_t'(($urandom_range(0, 31)) << 3));
      for (int k = 0; k < s.size(); k++)
        g.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      run(s, g, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
